// File: rtl/par2ser_pkg.sv
// Shared definitions for the 8-bit parallel-to-serial converter:
// word width, the idle value of the bit index, and the FSM state encoding.
package par2ser_pkg;

    // Parallel word width; the bit index is 3 bits, so only 8 is meaningful.
    localparam int P2S_W = 8;

    // Bit index shown on CTR while no word is being shifted out.
    localparam logic [2:0] CTR_IDLE = 3'b111;

    // Converter FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/par2ser_8_bit_ctr3.sv
// 3-bit bit-index down-counter for par2ser_8.
// Counts 7..0 while enabled and wraps 0 -> 7 naturally. It flags the terminal
// count at 0, and it exposes its next value so the owner can register outputs
// that depend on the index the counter is about to show.
module bit_ctr3
    import par2ser_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    output logic [2:0] cnt,
    output logic [2:0] cnt_nxt,
    output logic       tc
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Next count: reset and load force the idle index, otherwise step down by one.
    always_comb begin
        cnt_d = cnt_q;
        if (reset || load) begin
            cnt_d = CTR_IDLE;
        end else if (dec) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Count register.
    always_ff @(posedge CLK) begin
        cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;
    assign tc      = (cnt_q == 3'd0);

endmodule

// File: rtl/par2ser_8.sv
// par2ser_8: 8-bit parallel-to-serial converter, MSB first.
// A shifter register holds the word on the wire and a one-deep hold register
// skids the next word, so a steady upstream produces a gap-free bit stream.
// Every serial output is registered from next-state values. in_ready is the
// only combinational output.
module par2ser_8
    import par2ser_pkg::*;
#(
    parameter int W = P2S_W
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         ser_data,
    output logic         ser_valid,
    output logic         ser_first,
    output logic         ser_last,
    output logic [2:0]   CTR
);

    state_e         state_q;
    state_e         state_d;
    logic [W-1:0]   shifter_q;
    logic [W-1:0]   shifter_d;
    logic [W-1:0]   hold_q;
    logic [W-1:0]   hold_d;
    logic           hold_full_q;
    logic           hold_full_d;
    logic           ser_data_q;
    logic           ser_data_d;
    logic           ser_valid_q;
    logic           ser_valid_d;
    logic           ser_first_q;
    logic           ser_first_d;
    logic           ser_last_q;
    logic           ser_last_d;

    logic           accept;
    logic [2:0]     ctr_q;
    logic [2:0]     ctr_d;
    logic           ctr_tc;
    logic           ctr_load;
    logic           ctr_dec;

    // A word can be taken whenever the skid buffer is free and reset is low.
    assign in_ready = !hold_full_q && !reset;
    assign accept   = in_valid && in_ready;

    // The counter holds the idle index whenever the FSM is (or becomes) idle.
    // It steps down on every cycle spent shifting, and wraps 0 -> 7 between words.
    assign ctr_load = (state_d == ST_IDLE);
    assign ctr_dec  = (state_q == ST_SHIFT);

    bit_ctr3 u_bit_ctr3 (
        .CLK     (CLK),
        .reset   (reset),
        .load    (ctr_load),
        .dec     (ctr_dec),
        .cnt     (ctr_q),
        .cnt_nxt (ctr_d),
        .tc      (ctr_tc)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        state_q <= state_d;
    end

    // FSM next state: start on accept, keep shifting at bit 0 while a next word exists.
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ctr_tc) begin
                        state_d = (hold_full_q || accept) ? ST_SHIFT : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Word routing: load the shifter directly when idle, park mid-word arrivals in hold,
    // and at bit 0 refill the shifter from hold first (older word), else bypass the input.
    always_comb begin
        shifter_d   = shifter_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (reset) begin
            shifter_d   = '0;
            hold_d      = '0;
            hold_full_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shifter_d = in_data;
                    end
                end
                ST_SHIFT: begin
                    if (!ctr_tc) begin
                        if (accept) begin
                            hold_d      = in_data;
                            hold_full_d = 1'b1;
                        end
                    end else if (hold_full_q) begin
                        shifter_d   = hold_q;
                        hold_full_d = accept;
                        if (accept) begin
                            hold_d = in_data;
                        end
                    end else if (accept) begin
                        shifter_d = in_data;
                    end
                end
                default: begin
                    shifter_d   = shifter_q;
                    hold_d      = hold_q;
                    hold_full_d = hold_full_q;
                end
            endcase
        end
    end

    // FSM outputs: derived from next state, next word and next index so they can be registered.
    always_comb begin
        ser_valid_d = (state_d == ST_SHIFT);
        ser_data_d  = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        if (ser_valid_d) begin
            ser_data_d  = shifter_d[ctr_d];
            ser_first_d = (ctr_d == CTR_IDLE);
            ser_last_d  = (ctr_d == 3'd0);
        end
    end

    // Data and output registers; reset values come through the _d logic above.
    always_ff @(posedge CLK) begin
        shifter_q   <= shifter_d;
        hold_q      <= hold_d;
        hold_full_q <= hold_full_d;
        ser_data_q  <= ser_data_d;
        ser_valid_q <= ser_valid_d;
        ser_first_q <= ser_first_d;
        ser_last_q  <= ser_last_d;
    end

    assign ser_data  = ser_data_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign CTR       = ctr_q;

endmodule

// File: tb/tb_par2ser_8.sv
// Testbench for par2ser_8. The reference model treats the converter as a bit
// FIFO. An accepted word enqueues its 8 bits (MSB first, each tagged with its
// index). One bit leaves the queue per clock onto the serial outputs. The
// block is ready whenever fewer than 8 bits are still waiting behind the
// displayed bit.
module tb_par2ser_8;

    logic       CLK = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ser_data;
    logic       ser_valid;
    logic       ser_first;
    logic       ser_last;
    logic [2:0] CTR;

    par2ser_8 #(.W(8)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .CTR       (CTR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       b;
        logic [2:0] idx;
    } bit_t;

    bit_t       mq[$];
    logic       m_valid = 1'b0;
    logic       m_data  = 1'b0;
    logic [2:0] m_idx   = 3'd7;
    logic       m_acc   = 1'b0;

    int checks   = 0;
    int failures = 0;

    function automatic logic [7:0] exp_vec();
        logic e_first;
        logic e_last;
        logic e_ready;
        e_first = m_valid && (m_idx == 3'd7);
        e_last  = m_valid && (m_idx == 3'd0);
        e_ready = !reset && (mq.size() < 8);
        return {m_valid, (m_valid ? m_data : 1'b0), e_first, e_last,
                (m_valid ? m_idx : 3'd7), e_ready};
    endfunction

    function automatic logic [7:0] got_vec();
        return {ser_valid, ser_data, ser_first, ser_last, CTR, in_ready};
    endfunction

    // One clock: drive inputs, advance the model at the edge, settle past the edge.
    task automatic tick(input logic r, input logic v, input logic [7:0] d);
        bit_t e;
        reset    = r;
        in_valid = v;
        in_data  = d;
        m_acc    = v && !r && (mq.size() < 8);
        @(posedge CLK);
        if (r) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = 1'b0;
            m_idx   = 3'd7;
        end else begin
            if (m_acc) begin
                for (int i = 7; i >= 0; i--) begin
                    e.b   = d[i];
                    e.idx = 3'(i);
                    mq.push_back(e);
                end
            end
            if (mq.size() > 0) begin
                e       = mq.pop_front();
                m_valid = 1'b1;
                m_data  = e.b;
                m_idx   = e.idx;
            end else begin
                m_valid = 1'b0;
                m_data  = 1'b0;
                m_idx   = 3'd7;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b1, 8'hAA);
        checks++;
        if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_vec got=%b exp=%b", got_vec(), exp_vec());
        end
        checks++;
        if ({ser_valid, ser_data, ser_first, ser_last, CTR, in_ready} !== 8'b0000_111_0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", got_vec(), 8'b0000_111_0);
        end
        tick(1'b0, 1'b0, 8'h00);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_idle_inputs();
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 1'b0, 8'($urandom));
            checks++;
            if (ser_valid !== 1'b0 || CTR !== 3'b111 || got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL idle_inputs cyc%0d got=%b exp=%b", c, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        tick(1'b0, 1'b1, 8'hA5);
        checks++;
        if (ser_valid !== 1'b1 || ser_first !== 1'b1 || CTR !== 3'd7) begin
            failures++;
            $display("FAIL single_first got v=%b f=%b ctr=%0d exp v=1 f=1 ctr=7",
                     ser_valid, ser_first, CTR);
        end
        w = {7'd0, ser_data};
        for (int k = 1; k < 8; k++) begin
            tick(1'b0, 1'b0, 8'($urandom));
            checks++;
            if (got_vec() !== exp_vec() || CTR !== 3'(7 - k)) begin
                failures++;
                $display("FAIL single_bit k%0d got=%b exp=%b", k, got_vec(), exp_vec());
            end
            w = {w[6:0], ser_data};
        end
        checks++;
        if (w !== 8'hA5 || ser_last !== 1'b1) begin
            failures++;
            $display("FAIL single_word got=%h last=%b exp=a5 last=1", w, ser_last);
        end
        tick(1'b0, 1'b0, 8'h00);
        checks++;
        if (ser_valid !== 1'b0 || CTR !== 3'b111) begin
            failures++;
            $display("FAIL single_idle got v=%b ctr=%0d exp v=0 ctr=7", ser_valid, CTR);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  words [3];
        logic [23:0] stream;
        int          i;
        int          nvalid;
        int          gap;
        int          saw_stall;
        words[0] = 8'hFF;
        words[1] = 8'h00;
        words[2] = 8'h81;
        i = 0; nvalid = 0; gap = 0; saw_stall = 0; stream = '0;
        for (int c = 0; c < 40; c++) begin
            tick(1'b0, (i < 3), (i < 3) ? words[i] : 8'($urandom));
            if (m_acc) i++;
            checks++;
            if (got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL b2b cyc%0d got=%b exp=%b", c, got_vec(), exp_vec());
            end
            if (ser_valid === 1'b1) begin
                nvalid++;
                stream = {stream[22:0], ser_data};
            end else if (nvalid > 0 && nvalid < 24) begin
                gap = 1;
            end
            if (in_ready === 1'b0) saw_stall = 1;
        end
        checks++;
        if (nvalid != 24 || gap != 0 || stream !== 24'hFF0081 || saw_stall != 1) begin
            failures++;
            $display("FAIL b2b_stream got n=%0d gap=%0d data=%h stall=%0d exp n=24 gap=0 data=ff0081 stall=1",
                     nvalid, gap, stream, saw_stall);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] w;
        int         found;
        found = 0;
        tick(1'b0, 1'b1, 8'hC3);
        for (int c = 0; c < 12; c++) begin
            if (m_valid && m_idx == 3'd0) begin
                found = 1;
                break;
            end
            tick(1'b0, 1'b0, 8'($urandom));
            checks++;
            if (got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL bypass_c3 cyc%0d got=%b exp=%b", c, got_vec(), exp_vec());
            end
        end
        checks++;
        if (found != 1 || ser_last !== 1'b1 || ser_data !== 1'b1) begin
            failures++;
            $display("FAIL bypass_wrap_wait got found=%0d last=%b data=%b exp 1 1 1",
                     found, ser_last, ser_data);
        end
        tick(1'b0, 1'b1, 8'h3C);
        checks++;
        if (ser_valid !== 1'b1 || ser_first !== 1'b1 || CTR !== 3'd7 || ser_data !== 1'b0) begin
            failures++;
            $display("FAIL bypass_msb got v=%b f=%b ctr=%0d d=%b exp v=1 f=1 ctr=7 d=0",
                     ser_valid, ser_first, CTR, ser_data);
        end
        w = {7'd0, ser_data};
        for (int k = 1; k < 8; k++) begin
            tick(1'b0, 1'b0, 8'h00);
            w = {w[6:0], ser_data};
        end
        checks++;
        if (w !== 8'h3C) begin
            failures++;
            $display("FAIL bypass_word got=%h exp=3c", w);
        end
        tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_stall();
        logic [31:0] stream;
        int          n;
        int          stalled;
        stream = '0; n = 0; stalled = 0;
        tick(1'b0, 1'b1, 8'h11);
        if (ser_valid === 1'b1) begin n++; stream = {stream[30:0], ser_data}; end
        tick(1'b0, 1'b1, 8'h22);
        if (ser_valid === 1'b1) begin n++; stream = {stream[30:0], ser_data}; end
        for (int c = 0; c < 20; c++) begin
            if (mq.size() < 8) break;
            tick(1'b0, 1'b1, 8'h55);
            stalled++;
            checks++;
            if (got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stall cyc%0d got=%b exp=%b", c, got_vec(), exp_vec());
            end
            if (ser_valid === 1'b1) begin n++; stream = {stream[30:0], ser_data}; end
        end
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 1'b0, 8'h55);
            if (ser_valid === 1'b1) begin n++; stream = {stream[30:0], ser_data}; end
        end
        checks++;
        if (n != 16 || stream[15:0] !== 16'h1122 || stalled == 0) begin
            failures++;
            $display("FAIL stall_words got n=%0d data=%h stalled=%0d exp n=16 data=1122 stalled>0",
                     n, stream[15:0], stalled);
        end
    endtask

    task automatic test_reset_mid();
        int found;
        int nvalid;
        found = 0; nvalid = 0;
        tick(1'b0, 1'b1, 8'hF0);
        for (int c = 0; c < 12; c++) begin
            if (m_valid && m_idx == 3'd4) begin
                found = 1;
                break;
            end
            tick(1'b0, 1'b0, 8'h00);
        end
        checks++;
        if (found != 1 || CTR !== 3'd4) begin
            failures++;
            $display("FAIL reset_mid_reach got found=%0d ctr=%0d exp 1 4", found, CTR);
        end
        tick(1'b1, 1'b0, 8'h00);
        checks++;
        if (ser_valid !== 1'b0 || CTR !== 3'b111 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_abort got v=%b ctr=%0d rdy=%b exp v=0 ctr=7 rdy=0",
                     ser_valid, CTR, in_ready);
        end
        tick(1'b0, 1'b0, 8'h00);
        checks++;
        if (in_ready !== 1'b1 || got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_mid_release got=%b exp=%b", got_vec(), exp_vec());
        end
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 1'b0, 8'h00);
            if (ser_valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            failures++;
            $display("FAIL reset_mid_discard got valid_cycles=%0d exp=0", nvalid);
        end
    endtask

    task automatic test_random();
        logic r;
        logic v;
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            tick(r, v, 8'($urandom));
            checks++;
            if (got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc%0d got=%b exp=%b", c, got_vec(), exp_vec());
            end
        end
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 1'b0, 8'h00);
            checks++;
            if (got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_drain cyc%0d got=%b exp=%b", c, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_idle_inputs();
        test_single_word();
        test_back_to_back();
        test_bypass();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/par2ser_8.md
PAR2SER_8 -- requirements
Module: par2ser_8

Interface
REQ-001 SHALL have parameter W, default 8, giving the parallel word width; only W=8 is supported (3-bit bit index).
REQ-002 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream word available.
REQ-005 SHALL have port in_data  input  W  parallel word, sampled only on accept.
REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port ser_data  output  1  serial bit, MSB first.
REQ-008 SHALL have port ser_valid  output  1  ser_data carries a valid bit this cycle.
REQ-009 SHALL have port ser_first  output  1  high with the MSB (bit 7) of each word.
REQ-010 SHALL have port ser_last  output  1  high with the LSB (bit 0) of each word.
REQ-011 SHALL have port CTR  output  3  index of the bit currently on ser_data; 3'b111 when idle.

Function
REQ-012 SHALL accept a word on a rising CLK edge where in_valid and in_ready are both high.
REQ-013 SHALL hold words in two registers: shifter (word being output) and hold (one-deep skid buffer).
REQ-014 SHALL drive in_ready = not hold_full and not reset (combinational).
REQ-015 SHALL implement FSM states IDLE and SHIFT: IDLE->SHIFT on accept; SHIFT->SHIFT on bit 0 if a next word is available (hold full, or accept this edge); SHIFT->IDLE on bit 0 otherwise.
REQ-016 SHALL, in IDLE, load an accepted word directly into the shifter; ser_valid with bit 7 appears the cycle after accept (latency 1).
REQ-017 SHALL, in SHIFT, decrement CTR by 1 each cycle from 7 to 0; ser_data = shifter[CTR].
REQ-018 SHALL, in SHIFT with CTR != 0, write an accepted word into hold.
REQ-019 SHALL, at CTR = 0, load the shifter from hold if hold is full (hold becomes empty, and a simultaneous accept refills hold), otherwise from an accepted input word (bypass); CTR wraps 0->7 with no bubble cycle.
REQ-020 SHALL assert ser_first when CTR = 7 and ser_valid, and ser_last when CTR = 0 and ser_valid.
REQ-021 SHALL drive ser_valid = 1 in SHIFT only; in IDLE ser_data = 0, ser_first = ser_last = 0, CTR = 3'b111.
REQ-022 SHALL never drop or reorder an accepted word; words are output strictly in accept order.
REQ-023 SHALL ignore in_data when in_valid is low or in_ready is low.

Reset
REQ-024 SHALL, while reset is high at a CLK edge, set state = IDLE, CTR = 3'b111, hold_full = 0, shifter = hold = 0, and ser_data/ser_valid/ser_first/ser_last = 0.
REQ-025 SHALL abort any word in progress on reset, discarding shifter and hold contents.
REQ-026 SHALL keep in_ready = 0 while reset is high; in_ready = 1 on the first cycle after reset deasserts.

Structure
REQ-027 SHALL take W, the CTR idle value 3'b111 and the state encoding (IDLE = 0, SHIFT = 1) from shared package par2ser_pkg.
REQ-028 SHALL place the 3-bit down-counter (load 7, decrement, wrap, terminal-count flag at 0) in sub-module bit_ctr3, instantiated once.
REQ-029 SHALL register all outputs except in_ready.

Verification
REQ-030 Single word: reset 2 cycles, then in_data=8'hA5 valid 1 cycle -> ser_data 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after accept; ser_first on cycle 1; ser_last on cycle 8; CTR 7..0 then IDLE with CTR=7.
REQ-031 Back-to-back: in_valid held high with 8'hFF, 8'h00, 8'h81 -> 24 consecutive ser_valid cycles with no gap; in_ready low while hold full; output order FF, 00, 81.
REQ-032 Bypass at wrap: accept 8'hC3, then accept 8'h3C exactly when CTR=0 with hold empty -> 8'h3C MSB follows the 8'hC3 LSB on the next cycle.
REQ-033 Reset mid-word: accept 8'hF0, assert reset at CTR=4 -> next cycle ser_valid=0, CTR=7, in_ready=0 during reset and 1 after; 8'hF0 is never completed.
REQ-034 Stall rejection: hold full and in_valid high with 8'h55 while in_ready=0 -> 8'h55 never appears on ser_data until a later accept.
REQ-035 Idle inputs: in_valid low with in_data toggling for 20 cycles -> ser_valid stays 0 and CTR stays 7.
